// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return-address stack
// Priority: exc > branch_taken > hazrd > ret > call > jump > sequential.
module pc_sequencer #(
  parameter int WIDTH     = 16,
  parameter int STEP      = 2,
  parameter int RESET_VEC = 0,
  parameter int EXC_VEC   = 16'h0010,
  parameter int RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hazrd,
  input  logic                             exc,
  input  logic                             branch_taken,
  input  logic [WIDTH-1:0]                 branch_target,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic [WIDTH-1:0]                 jump_target,
  output logic [WIDTH-1:0]                 PCout,
  output logic [WIDTH-1:0]                 PCnext,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ras_err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_V   = WIDTH'(EXC_VEC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] top_entry;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [WIDTH-1:0] stack_d [RAS_DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             err_q, err_d;

  assign seq_pc = pc_q + STEP_V;

  // Entry 0 is the oldest; the top lives at index cnt_q-1.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (i + 1 == int'(cnt_q)) top_entry = stack_q[i];
    end
  end

  always_comb begin
    pc_d    = seq_pc;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (rst) begin
      pc_d = RESET_V;
    end else if (exc) begin
      pc_d = EXC_V;
    end else if (branch_taken) begin
      pc_d = branch_target;
    end else if (hazrd) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_d  = top_entry;
        cnt_d = cnt_q - CW'(1);
      end else begin
        pc_d  = EXC_V;
        err_d = 1'b1;
      end
    end else if (call) begin
      pc_d = jump_target;
      if (int'(cnt_q) == RAS_DEPTH) begin
        // Full stack: slide everything down, dropping the oldest return address.
        for (int i = 0; i < RAS_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
        stack_d[RAS_DEPTH-1] = seq_pc;
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
          if (i == int'(cnt_q)) stack_d[i] = seq_pc;
        end
        cnt_d = cnt_q + CW'(1);
      end
    end else if (jump) begin
      pc_d = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_V;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
      stack_q <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      full_q  <= (int'(cnt_d) == RAS_DEPTH);
      empty_q <= (cnt_d == '0);
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign PCout     = pc_q;
  assign PCnext    = pc_d;
  assign ras_count = cnt_q;
  assign ras_full  = full_q;
  assign ras_empty = empty_q;
  assign ras_err   = err_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  16  PC and target width in bits.
  STEP  2  Sequential increment added to PC each advancing cycle.
  RESET_VEC  0  PC value loaded on reset.
  EXC_VEC  16'h0010  Exception / RAS-underflow vector, truncated to WIDTH.
  RAS_DEPTH  4  Return-address stack entries, integer >= 2.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  input  1  Single clock; all state updates on its rising edge.
  rst  input  1  Synchronous, active-high reset.
  hazrd  input  1  Stall request from hazard unit.
  exc  input  1  Exception request.
  branch_taken  input  1  Resolved taken branch.
  branch_target  input  WIDTH  Branch destination.
  jump  input  1  Unconditional jump.
  call  input  1  Call: push return address, go to jump_target.
  ret  input  1  Return: pop RAS, go to popped address.
  jump_target  input  WIDTH  Jump/call destination.
  PCout  output  WIDTH  Registered current PC.
  PCnext  output  WIDTH  Combinational value PCout takes at next edge.
  ras_count  output  clog2(RAS_DEPTH+1)  Valid RAS entries.
  ras_full  output  1  ras_count == RAS_DEPTH.
  ras_empty  output  1  ras_count == 0.
  ras_err  output  1  Sticky: RAS overflow or underflow occurred.

Function
REQ-003 PCout SHALL update every rising clk edge to PCnext; no other path modifies it.
REQ-004 PCnext SHALL be selected by strict priority: exc > branch_taken > hazrd > ret > call > jump > sequential.
REQ-005 exc: PCnext = EXC_VEC; RAS unchanged; all lower-priority inputs ignored that cycle.
REQ-006 branch_taken: PCnext = branch_target; overrides hazrd (flush); RAS unchanged.
REQ-007 hazrd (no exc/branch_taken): PCnext = PCout; RAS unchanged; call/ret/jump discarded, not queued.
REQ-008 ret, RAS non-empty: PCnext = top entry; entry popped; ras_count decrements at the same edge.
REQ-009 ret, RAS empty: PCnext = EXC_VEC; ras_count stays 0; ras_err set.
REQ-010 call: PCnext = jump_target; (PCout + STEP) mod 2^WIDTH pushed at the same edge.
REQ-011 call with RAS full: oldest entry discarded, new entry becomes top, ras_count stays RAS_DEPTH, ras_err set.
REQ-012 call and ret together: ret SHALL win per REQ-004; call ignored, no push.
REQ-013 jump (no call/ret): PCnext = jump_target; RAS unchanged.
REQ-014 Sequential: PCnext = (PCout + STEP) mod 2^WIDTH; wrap from 2^WIDTH-STEP to 0 silently.
REQ-015 ras_full, ras_empty, ras_count SHALL be registered, consistent with each other every cycle.
REQ-016 Pushed/popped addresses SHALL be exactly WIDTH bits; no sign extension.
REQ-017 ras_err SHALL stay set until reset; no other clear mechanism.

Reset
REQ-018 While rst is high at a rising edge: PCout = RESET_VEC, ras_count = 0, ras_empty = 1, ras_full = 0, ras_err = 0; all other inputs ignored.
REQ-019 rst SHALL override every input including exc, and mid-call/ret it SHALL discard stack contents.
REQ-020 PCnext SHALL equal RESET_VEC whenever rst is high.
REQ-021 First edge after rst deasserts SHALL apply REQ-004 normally from PCout = RESET_VEC.

Verification
REQ-022 Reset, then 3 idle cycles (WIDTH=16, STEP=2) -> PCout 0x0000, 0x0002, 0x0004, 0x0006.
REQ-023 PCout=0x0010, hazrd 2 cycles then branch_taken with hazrd, branch_target 0x0100 -> PCout 0x0010, 0x0010, 0x0100.
REQ-024 PCout=0x0020, call jump_target 0x0200; 2 idle; ret -> PCout 0x0200, 0x0202, 0x0204, 0x0022; ras_count 1 then 0.
REQ-025 RAS_DEPTH=4, 5 calls from 0x0000, 0x1000, 0x2000, 0x3000, 0x4000 -> ras_full=1, ras_err=1; 4 rets return 0x4002, 0x3002, 0x2002, 0x1002; 5th ret -> EXC_VEC 0x0010.
REQ-026 PCout=0xFFFE idle -> 0x0000; exc with branch_taken and call together -> PCout 0x0010, ras_count unchanged.
REQ-027 rst asserted the same cycle as call with ras_count=2 -> PCout=RESET_VEC, ras_count=0, ras_err=0 next cycle.
